// File: rtl/ram_access_controller_if.sv
// ram_access_controller_if: bundle of request/response, preload and RAM pin signals
//   req_valid/req_ready/req_write/req_addr/req_wdata : load/store request handshake
//   rsp_valid/rsp_rdata                              : one-cycle load response
//   init_start/init_busy                             : preload sweep control/status
//   ram_we/ram_address/ram_input/ram_output          : synchronous-read RAM pins
//   master = datapath + RAM side, slave = controller side
interface ram_access_controller_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_start;
    logic              init_busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_input;
    logic [DATA_W-1:0] ram_output;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, init_start, ram_output,
        input  req_ready, rsp_valid, rsp_rdata, init_busy, ram_we, ram_address, ram_input
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, init_start, ram_output,
        output req_ready, rsp_valid, rsp_rdata, init_busy, ram_we, ram_address, ram_input
    );
endinterface

// File: rtl/ram_access_controller.sv
// ram_access_controller: initiator-side controller for a 32x8 synchronous-read RAM
//   clock : system clock, posedge
//   reset : synchronous active-high reset
//   bus   : ram_access_controller_if.slave (request/response, preload, RAM pins)
module ram_access_controller #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 32,
    parameter int INIT_WORD0 = 170
) (
    input logic                    clock,
    input logic                    reset,
    ram_access_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, INIT} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                // preload wins over a simultaneous request, which stays unaccepted
                if (bus.init_start) begin
                    we_d    = 1'b1;
                    addr_d  = '0;
                    din_d   = DATA_W'(INIT_WORD0);
                    state_d = INIT;
                end else if (bus.req_valid) begin
                    we_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    din_d   = bus.req_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // RAM samples now; a load's data appears on ram_output one edge later
                we_d    = 1'b0;
                state_d = we_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                rdata_d     = bus.ram_output;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            INIT: begin
                if (addr_q == ADDR_W'(DEPTH - 1)) begin
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    din_d  = DATA_W'(addr_q + ADDR_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE) && !bus.init_start;
    assign bus.init_busy   = (state_q == INIT);
    assign bus.ram_we      = we_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_input   = din_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
endmodule

// File: tb/tb_ram_access_controller.sv
// tb_ram_access_controller: directed + randomized bench with a timeline model of expected outputs
module tb_ram_access_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ram_access_controller_if #(.ADDR_W(5), .DATA_W(8)) bus();
    ram_access_controller dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    logic [7:0] ram [32];
    always @(posedge clock) begin
        if (bus.ram_we) ram[bus.ram_address] <= bus.ram_input;
        else bus.ram_output <= ram[bus.ram_address];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Expected register-output state after each edge; a transaction schedules a run of these.
    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] din;
        logic       rv;
        logic [7:0] rd;
        logic       busy;
        logic       ini;
    } rec_t;

    rec_t       cur;
    rec_t       q[$];
    logic [7:0] shadow [32];

    initial begin
        logic       s_rst, s_v, s_w, s_init;
        logic [4:0] s_a;
        logic [7:0] s_d;
        cur = '0;
        forever begin
            @(posedge clock);
            s_rst = reset; s_v = bus.req_valid; s_w = bus.req_write;
            s_a = bus.req_addr; s_d = bus.req_wdata; s_init = bus.init_start;
            #1;
            if (cur.we) shadow[cur.addr] = cur.din;
            if (s_rst) begin
                q.delete();
                cur = '0;
            end else begin
                if (!cur.busy && s_init) begin
                    for (int i = 0; i < 32; i++)
                        q.push_back(rec_t'{1'b1, 5'(i), (i == 0) ? 8'd170 : 8'(i), 1'b0, cur.rd, 1'b1, 1'b1});
                end else if (!cur.busy && s_v) begin
                    if (s_w) q.push_back(rec_t'{1'b1, s_a, s_d, 1'b0, cur.rd, 1'b1, 1'b0});
                    else begin
                        q.push_back(rec_t'{1'b0, s_a, s_d, 1'b0, cur.rd, 1'b1, 1'b0});
                        q.push_back(rec_t'{1'b0, s_a, s_d, 1'b0, cur.rd, 1'b1, 1'b0});
                        q.push_back(rec_t'{1'b0, s_a, s_d, 1'b1, shadow[s_a], 1'b0, 1'b0});
                    end
                end
                if (q.size() > 0) cur = q.pop_front();
                else begin
                    cur.we = 1'b0; cur.rv = 1'b0; cur.busy = 1'b0; cur.ini = 1'b0;
                end
            end
            chk("m_ram_we", 32'(bus.ram_we), 32'(cur.we));
            chk("m_ram_address", 32'(bus.ram_address), 32'(cur.addr));
            chk("m_ram_input", 32'(bus.ram_input), 32'(cur.din));
            chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(cur.rv));
            chk("m_rsp_rdata", 32'(bus.rsp_rdata), 32'(cur.rd));
            chk("m_init_busy", 32'(bus.init_busy), 32'(cur.ini));
            chk("m_req_ready", 32'(bus.req_ready), 32'(!cur.busy && !bus.init_start));
        end
    end

    task automatic issue(input logic w, input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
        #1;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock); #1;
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic load_chk(input logic [4:0] a, input logic [7:0] exp);
        int n = 0;
        issue(1'b0, a, 8'h00);
        do begin
            @(negedge clock);
            n++;
        end while (!bus.rsp_valid && n < 20);
        chk("load_latency", 32'(n), 32'd2);
        chk("load_rdata", 32'(bus.rsp_rdata), 32'(exp));
        @(negedge clock);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic run_init();
        int i = 0;
        @(negedge clock); bus.init_start = 1'b1;
        @(negedge clock); bus.init_start = 1'b0;
        while (bus.init_busy && i < 100) begin
            chk("init_we", 32'(bus.ram_we), 32'd1);
            chk("init_addr", 32'(bus.ram_address), 32'(i));
            chk("init_data", 32'(bus.ram_input), (i == 0) ? 32'd170 : 32'(i));
            i++;
            @(negedge clock);
        end
        chk("init_len", 32'(i), 32'd32);
        chk("init_we_off", 32'(bus.ram_we), 32'd0);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.init_start = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_we", 32'(bus.ram_we), 32'd0);
        chk("rst_addr", 32'(bus.ram_address), 32'd0);
        chk("rst_input", 32'(bus.ram_input), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_init_busy", 32'(bus.init_busy), 32'd0);
        reset = 1'b0;

        run_init();
        load_chk(5'd0, 8'd170);

        issue(1'b1, 5'd5, 8'h3C);
        chk("store_ready_low", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        chk("store_ready_high", 32'(bus.req_ready), 32'd1);
        load_chk(5'd5, 8'h3C);
        load_chk(5'd6, 8'd6);

        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'd31;
        @(negedge clock);
        chk("b2b_ready_access", 32'(bus.req_ready), 32'd0);
        bus.req_addr = 5'd30;
        @(negedge clock);
        chk("b2b_ready_capture", 32'(bus.req_ready), 32'd0);
        chk("b2b_rv_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        chk("b2b_rv_31", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rd_31", 32'(bus.rsp_rdata), 32'd31);
        chk("b2b_ready_idle", 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("b2b_rv_gap1", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        chk("b2b_rv_gap2", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        chk("b2b_rv_30", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rd_30", 32'(bus.rsp_rdata), 32'd30);

        @(negedge clock);
        bus.init_start = 1'b1; bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 5'd2; bus.req_wdata = 8'hFF;
        @(negedge clock);
        bus.init_start = 1'b0;
        n = 0;
        while (bus.init_busy && n < 100) begin
            chk("coll_ready", 32'(bus.req_ready), 32'd0);
            chk("coll_no_store", 32'(bus.ram_input == 8'hFF), 32'd0);
            n++;
            @(negedge clock);
        end
        chk("coll_len", 32'(n), 32'd32);
        chk("coll_ready_after", 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        chk("coll_store_we", 32'(bus.ram_we), 32'd1);
        chk("coll_store_addr", 32'(bus.ram_address), 32'd2);
        chk("coll_store_data", 32'(bus.ram_input), 32'hFF);
        bus.req_valid = 1'b0;
        load_chk(5'd2, 8'hFF);

        @(negedge clock); bus.init_start = 1'b1;
        @(negedge clock); bus.init_start = 1'b0;
        n = 0;
        while (bus.ram_address != 5'd10 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("abort_reached_10", 32'(bus.ram_address), 32'd10);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_we", 32'(bus.ram_we), 32'd0);
        chk("abort_busy", 32'(bus.init_busy), 32'd0);
        chk("abort_addr", 32'(bus.ram_address), 32'd0);
        chk("abort_input", 32'(bus.ram_input), 32'd0);
        chk("abort_rv", 32'(bus.rsp_valid), 32'd0);
        chk("abort_rd", 32'(bus.rsp_rdata), 32'd0);
        run_init();
        load_chk(5'd31, 8'd31);

        issue(1'b0, 5'd7, 8'h00);
        bus.init_start = 1'b1;
        @(negedge clock);
        bus.init_start = 1'b0;
        chk("pend_busy1", 32'(bus.init_busy), 32'd0);
        @(negedge clock);
        chk("pend_rv", 32'(bus.rsp_valid), 32'd1);
        chk("pend_rd", 32'(bus.rsp_rdata), 32'd7);
        chk("pend_busy2", 32'(bus.init_busy), 32'd0);

        repeat (1500) begin
            @(negedge clock);
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_write  = 1'($urandom_range(0, 1));
            bus.req_addr   = 5'($urandom_range(0, 31));
            bus.req_wdata  = 8'($urandom_range(0, 255));
            bus.init_start = ($urandom_range(0, 39) == 0);
            reset          = ($urandom_range(0, 199) == 0);
        end
        @(negedge clock);
        bus.req_valid = 1'b0; bus.init_start = 1'b0; reset = 1'b0;
        repeat (40) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
